// File: rtl/demux2_tdm.sv
// Splits an interleaved A/B word stream into two valid/ready channels.
// Slot alignment comes from the sync marker carried by every slot-A word.
module demux2_tdm #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic             sync_err,
  output logic [CNT_W-1:0] pair_count
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    EXP_A = 2'd1,
    EXP_B = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_data_q, a_data_d;
  logic [WIDTH-1:0]   b_data_q, b_data_d;
  logic               a_valid_q, a_valid_d;
  logic               b_valid_q, b_valid_d;
  logic               sync_err_q, sync_err_d;
  logic [CNT_W-1:0]   pair_count_q, pair_count_d;
  logic               in_ready_c;
  logic               xfer_c;
  logic               a_space_c;
  logic               b_space_c;

  // A holding register can take a word when empty or draining this cycle.
  always_comb begin
    a_space_c = !a_valid_q || a_ready;
    b_space_c = !b_valid_q || b_ready;
    unique case (state_q)
      EXP_A:   in_ready_c = a_space_c;
      EXP_B:   in_ready_c = b_space_c;
      default: in_ready_c = 1'b1;
    endcase
    xfer_c = in_valid && in_ready_c;
  end

  always_comb begin
    state_d      = state_q;
    a_data_d     = a_data_q;
    b_data_d     = b_data_q;
    a_valid_d    = a_valid_q && !a_ready;
    b_valid_d    = b_valid_q && !b_ready;
    sync_err_d   = 1'b0;
    pair_count_d = pair_count_q;

    if (xfer_c) begin
      unique case (state_q)
        HUNT: begin
          // Locking word never overwrites an unconsumed A word.
          if (in_sync) begin
            state_d = EXP_B;
            if (a_space_c) begin
              a_data_d  = in_data;
              a_valid_d = 1'b1;
            end
          end
        end
        EXP_A: begin
          if (in_sync) begin
            a_data_d  = in_data;
            a_valid_d = 1'b1;
            state_d   = EXP_B;
          end else begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end
        end
        EXP_B: begin
          if (!in_sync) begin
            b_data_d     = in_data;
            b_valid_d    = 1'b1;
            pair_count_d = pair_count_q + CNT_W'(1);
            state_d      = EXP_A;
          end else begin
            // Resync: the marked word restarts the pair as a new slot-A word.
            sync_err_d = 1'b1;
            if (a_space_c) begin
              a_data_d  = in_data;
              a_valid_d = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      a_data_q     <= '0;
      b_data_q     <= '0;
      a_valid_q    <= 1'b0;
      b_valid_q    <= 1'b0;
      sync_err_q   <= 1'b0;
      pair_count_q <= '0;
    end else begin
      state_q      <= state_d;
      a_data_q     <= a_data_d;
      b_data_q     <= b_data_d;
      a_valid_q    <= a_valid_d;
      b_valid_q    <= b_valid_d;
      sync_err_q   <= sync_err_d;
      pair_count_q <= pair_count_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign a_data     = a_data_q;
  assign a_valid    = a_valid_q;
  assign b_data     = b_data_q;
  assign b_valid    = b_valid_q;
  assign sync_err   = sync_err_q;
  assign pair_count = pair_count_q;

endmodule

// File: tb/tb_demux2_tdm.sv
// Scoreboard bench for demux2_tdm: a slot-level reference model predicts each
// channel's word sequence, handshake flags, error pulses and pair count.
module tb_demux2_tdm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sync = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_ready;
  logic [3:0] a_data;
  logic       a_valid;
  logic       a_ready = 1'b1;
  logic [3:0] b_data;
  logic       b_valid;
  logic       b_ready = 1'b1;
  logic       sync_err;
  logic [7:0] pair_count;

  int checks = 0;
  int failures = 0;
  bit rand_rdy = 1'b0;

  // Reference model: alignment knowledge plus queues of words owed downstream.
  bit         locked, want_b, a_full, b_full, exp_err;
  int         pairs;
  logic [3:0] qa[$];
  logic [3:0] qb[$];

  demux2_tdm #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sync(in_sync), .in_data(in_data), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .sync_err(sync_err), .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    if (!locked) return 1'b1;
    if (want_b) return !b_full || b_ready;
    return !a_full || a_ready;
  endfunction

  // Model update on each clock edge, from the inputs presented before it.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        locked = 0; want_b = 0; a_full = 0; b_full = 0; exp_err = 0; pairs = 0;
        qa.delete(); qb.delete();
      end else begin
        bit ld_a, ld_b, err, a_space;
        ld_a = 0; ld_b = 0; err = 0;
        a_space = !a_full || a_ready;
        if (in_valid && model_ready()) begin
          if (!locked) begin
            if (in_sync) begin locked = 1; want_b = 1; ld_a = a_space; end
          end else if (!want_b) begin
            if (in_sync) begin want_b = 1; ld_a = 1; end
            else begin err = 1; locked = 0; end
          end else begin
            if (!in_sync) begin ld_b = 1; pairs++; want_b = 0; end
            else begin err = 1; ld_a = a_space; end
          end
        end
        a_full = ld_a || (a_full && !a_ready);
        b_full = ld_b || (b_full && !b_ready);
        if (ld_a) qa.push_back(in_data);
        if (ld_b) qb.push_back(in_data);
        exp_err = err;
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle and retires consumed words.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", in_ready, model_ready());
        chk("a_valid", a_valid, a_full);
        chk("b_valid", b_valid, b_full);
        chk("sync_err", sync_err, exp_err);
        chk("pair_count", pair_count, pairs % 256);
        if (a_valid) begin
          if (qa.size() == 0) chk("a_unexpected", 1, 0);
          else begin
            chk("a_data", a_data, qa[0]);
            if (a_ready) void'(qa.pop_front());
          end
        end
        if (b_valid) begin
          if (qb.size() == 0) chk("b_unexpected", 1, 0);
          else begin
            chk("b_data", b_data, qb[0]);
            if (b_ready) void'(qb.pop_front());
          end
        end
      end
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        a_ready = ($urandom_range(0, 3) != 0);
        b_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic send(input logic [3:0] d, input logic s);
    bit got;
    int n;
    in_valid = 1'b1; in_data = d; in_sync = s;
    n = 0;
    forever begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit s;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Lock and split
    send(4'hA, 0); send(4'h3, 1); send(4'hC, 0); send(4'h5, 1); send(4'h9, 0);
    idle(2);
    chk("pairs_after_split", pair_count, 2);

    // Backpressure on B while in EXP_B
    b_ready = 0;
    send(4'h1, 1); send(4'hC, 0); send(4'h4, 1);
    in_valid = 1; in_data = 4'h7; in_sync = 0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_b_data", b_data, 4'hC);
      @(posedge clk);
      #1;
    end
    b_ready = 1;
    send(4'h7, 0);
    idle(1);
    chk("bp_release_b_data", b_data, 4'h7);

    // Missing sync, then relock
    send(4'h2, 0);
    send(4'h6, 1);
    idle(1);
    chk("relock_a_data", a_data, 4'h6);

    // Double sync in EXP_B
    send(4'hE, 1);
    idle(1);
    chk("dsync_a_data", a_data, 4'hE);
    send(4'hB, 0);
    idle(2);

    // Async reset mid-cycle while A holds a word
    a_ready = 0;
    send(4'h8, 1);
    @(negedge clk);
    chk("pre_reset_a_valid", a_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_pair_count", pair_count, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_in_ready", in_ready, 1);
    a_ready = 1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Wrap: 256 pairs at full throughput with every 4-bit value on both channels
    for (int i = 0; i < 256; i++) begin
      send(4'(i), 1);
      send(4'(15 - (i % 16)), 0);
    end
    idle(2);
    chk("wrap_pair_count", pair_count, 0);

    // Randomized traffic with random backpressure and occasional slot errors
    do_reset();
    rand_rdy = 1;
    s = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      send(4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0) ? !s : s);
      s = !s;
    end
    rand_rdy = 0;
    #1 a_ready = 1; b_ready = 1;
    idle(4);
    chk("drain_qa", qa.size(), 0);
    chk("drain_qb", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux2_tdm.md
Name: demux2_tdm

Overview:
- Receive-side counterpart of the 2:1 word multiplexer.
- Accepts a time-interleaved stream of WIDTH-bit words (slot A, slot B, A, B, …) and separates it back into two independent output channels.
- Each channel has a one-entry holding register with a valid/ready handshake.
- Slot alignment is recovered from a sync marker on every slot-A word; misalignment is detected and reported.

Parameters:
- WIDTH, 4, data word width of the input and both output channels.
- CNT_W, 8, width of the completed-pair counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_sync carry a word this cycle.
- in_sync  input  1  high marks the current word as a slot-A word.
- in_data  input  WIDTH  interleaved input word.
- in_ready  output  1  block accepts the word this cycle; transfer = in_valid & in_ready.
- a_data  output  WIDTH  channel A word, registered.
- a_valid  output  1  a_data holds an unconsumed word.
- a_ready  input  1  downstream consumes channel A; consumption = a_valid & a_ready.
- b_data  output  WIDTH  channel B word, registered.
- b_valid  output  1  b_data holds an unconsumed word.
- b_ready  input  1  downstream consumes channel B.
- sync_err  output  1  one-cycle pulse on detected slot misalignment.
- pair_count  output  CNT_W  number of completed A+B pairs, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0):
  - FSM = HUNT.
  - a_data, b_data = 0; a_valid, b_valid = 0.
  - sync_err = 0; pair_count = 0.
  - Reset mid-transfer discards any held words immediately.
- FSM states: HUNT, EXP_A, EXP_B.
- HUNT:
  - in_ready = 1.
  - Transfer with in_sync=0: word discarded; stay HUNT.
  - Transfer with in_sync=1: word loaded into channel A; go to EXP_B.
- EXP_A:
  - in_ready = !a_valid | a_ready.
  - Transfer with in_sync=1: load A; go to EXP_B.
  - Transfer with in_sync=0: word discarded; sync_err pulses next cycle; go to HUNT.
- EXP_B:
  - in_ready = !b_valid | b_ready.
  - Transfer with in_sync=0: load B; pair_count += 1; go to EXP_A.
  - Transfer with in_sync=1 (resync case): sync_err pulses; word treated as a new slot-A word.
    - Loaded into A only if !a_valid | a_ready this cycle; otherwise dropped.
    - Stay in EXP_B. pair_count is unchanged.
- Load timing:
  - A loaded word appears on x_data with x_valid=1 the cycle after the transfer edge.
  - Latency is 1 clock.
- Holding registers:
  - x_data is stable while x_valid=1 and x_ready=0.
  - x_valid clears after consumption unless a new load occurs in the same cycle.
  - Simultaneous consume + load: x_valid stays 1 and x_data updates. Full throughput of one word per cycle is sustained.
- Backpressure:
  - While in_ready=0, in_data/in_sync are ignored and the state holds.
  - Upstream must hold its word until in_ready=1.
- sync_err is registered, high for exactly one cycle per error event.
- pair_count: 2^CNT_W−1 + 1 → 0, with no flag.
- in_valid=0: no state change except handshake clearing on the outputs.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle with a_valid=1 → a_valid, b_valid, pair_count, sync_err go to 0 immediately; FSM is HUNT.
- Lock and split: after reset drive (4'hA, sync=0), then (4'h3, sync=1), (4'hC, sync=0), (4'h5, sync=1), (4'h9, sync=0), with a_ready=b_ready=1.
  - First word is discarded.
  - A channel outputs 3, 5; B channel outputs C, 9.
  - pair_count = 2; sync_err never asserted.
- Backpressure: hold b_ready=0 with b_valid=1 and FSM in EXP_B → in_ready=0.
  - Presented word 4'h7 is not consumed and b_data stays 4'hC.
  - Release b_ready → 4'h7 loads the next cycle.
- Missing sync: in EXP_A drive (4'h2, sync=0) → sync_err pulses 1 cycle, word dropped, FSM=HUNT.
  - Following (4'h6, sync=1) appears on a_data.
- Double sync: in EXP_B drive (4'hE, sync=1) → sync_err pulses, a_data=E, pair_count unchanged, FSM stays EXP_B.
- Wrap: run 256 valid pairs with CNT_W=8 → pair_count returns to 0; exhaustive 4-bit values 0..F on both channels match the expected de-interleaved sequence with 0 errors.
